// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Hazard controller for a five-stage in-order pipeline. It issues the
// pipeline-register write enables and NOP-insertion controls for three cases:
// a load-use data hazard, a taken branch resolved in EX, and a data-memory
// access that has not completed. It also keeps a few statistics counters.
//
// Ports
//   clk            in   rising-edge clock for all state
//   reset          in   synchronous, active-high reset
//   id_valid       in   ID stage holds a real instruction
//   id_rn          in   [4:0] ID first source register
//   id_rm          in   [4:0] ID second source register (after Reg2Loc select)
//   id_uses_rm     in   ID instruction reads id_rm
//   ex_valid       in   EX stage holds a real instruction
//   ex_rd          in   [4:0] EX destination register
//   ex_mem_read    in   EX instruction is a load
//   ex_br_taken    in   EX resolved a taken branch
//   mem_req        in   MEM stage is accessing data memory
//   mem_ready      in   data memory completes the access this cycle
//   pc_en, ifid_en, idex_en, exmem_en   out  PC / pipeline register enables
//   ifid_flush, idex_bubble, memwb_bubble out  load a NOP into that register
//   mem_timeout    out  sticky flag: a memory wait ran out of patience
//   stall_cycles   out  [31:0] cycles with pc_en low (saturating)
//   branch_flushes out  [15:0] taken branches that caused a flush (saturating)
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        id_valid,
    input  logic [4:0]  id_rn,
    input  logic [4:0]  id_rm,
    input  logic        id_uses_rm,
    input  logic        ex_valid,
    input  logic [4:0]  ex_rd,
    input  logic        ex_mem_read,
    input  logic        ex_br_taken,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        idex_en,
    output logic        exmem_en,
    output logic        ifid_flush,
    output logic        idex_bubble,
    output logic        memwb_bubble,
    output logic        mem_timeout,
    output logic [31:0] stall_cycles,
    output logic [15:0] branch_flushes
);

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_FLUSH    = 2'd1,
        S_MEM_WAIT = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_wait_cnt;
    logic        r_timeout;
    logic [31:0] r_stall_cnt;
    logic [15:0] r_br_cnt;

    logic w_load_use;
    logic w_branch;
    logic w_mem_stall;
    logic w_freeze;
    logic w_enter_wait;
    logic w_enter_flush;
    logic w_timeout_hit;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // XZR (register 31) is hard-wired zero, so a load targeting it never
    // produces a value anyone can depend on.
    assign w_load_use  = ex_valid & ex_mem_read & (ex_rd != 5'd31) & id_valid &
                         ((ex_rd == id_rn) | (id_uses_rm & (ex_rd == id_rm)));
    assign w_branch    = ex_valid & ex_br_taken;
    assign w_mem_stall = mem_req & ~mem_ready;

    always_comb begin
        w_next        = r_state;
        pc_en         = 1'b1;
        ifid_en       = 1'b1;
        idex_en       = 1'b1;
        exmem_en      = 1'b1;
        ifid_flush    = 1'b0;
        idex_bubble   = 1'b0;
        memwb_bubble  = 1'b0;
        w_freeze      = 1'b0;
        w_enter_wait  = 1'b0;
        w_enter_flush = 1'b0;
        w_timeout_hit = 1'b0;

        if (reset) begin
            // Enables stay high so every pipeline register captures a NOP.
            ifid_flush   = 1'b1;
            idex_bubble  = 1'b1;
            memwb_bubble = 1'b1;
            w_next       = S_RUN;
        end else begin
            case (r_state)
                S_RUN: begin
                    // Priority: memory stall > taken branch > load-use.
                    // A frozen branch stays in EX and is re-evaluated later.
                    if (w_mem_stall) begin
                        w_freeze     = 1'b1;
                        w_enter_wait = 1'b1;
                        w_next       = S_MEM_WAIT;
                    end else if (w_branch) begin
                        ifid_flush    = 1'b1;
                        idex_bubble   = 1'b1;
                        w_enter_flush = 1'b1;
                        w_next        = S_FLUSH;
                    end else if (w_load_use) begin
                        pc_en       = 1'b0;
                        ifid_en     = 1'b0;
                        idex_bubble = 1'b1;
                    end
                end
                S_FLUSH: begin
                    // Second flush cycle covers the synchronous instruction
                    // memory, which already fetched down the wrong path.
                    if (w_mem_stall) begin
                        w_freeze     = 1'b1;
                        w_enter_wait = 1'b1;
                        w_next       = S_MEM_WAIT;
                    end else begin
                        ifid_flush = 1'b1;
                        w_next     = S_RUN;
                    end
                end
                S_MEM_WAIT: begin
                    if (!mem_ready) begin
                        w_freeze = 1'b1;
                        // This is the 255th waiting cycle: give up.
                        if (r_wait_cnt == 8'd254) begin
                            w_timeout_hit = 1'b1;
                            w_next        = S_RUN;
                        end
                    end else begin
                        w_next = S_RUN;
                    end
                end
                default: w_next = S_RUN;
            endcase

            if (w_freeze) begin
                pc_en        = 1'b0;
                ifid_en      = 1'b0;
                idex_en      = 1'b0;
                exmem_en     = 1'b0;
                ifid_flush   = 1'b0;
                idex_bubble  = 1'b0;
                memwb_bubble = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_RUN;
            r_wait_cnt  <= 8'd0;
            r_timeout   <= 1'b0;
            r_stall_cnt <= 32'd0;
            r_br_cnt    <= 16'd0;
        end else begin
            r_state <= w_next;
            if (w_enter_wait) begin
                r_wait_cnt <= 8'd0;
            end else if ((r_state == S_MEM_WAIT) && !mem_ready) begin
                r_wait_cnt <= r_wait_cnt + 8'd1;
            end
            if (w_timeout_hit) begin
                r_timeout <= 1'b1;
            end
            if (!pc_en) begin
                r_stall_cnt <= sat_inc32(r_stall_cnt);
            end
            if (w_enter_flush) begin
                r_br_cnt <= sat_inc16(r_br_cnt);
            end
        end
    end

    assign mem_timeout    = r_timeout;
    assign stall_cycles   = r_stall_cnt;
    assign branch_flushes = r_br_cnt;

endmodule
